// File: rtl/lsu_bus_master_if.sv
// Bundles the CPU request/response handshake and the word-wide data port of the LSU.
// The master modport is the LSU side; the slave modport is the CPU/memory side.
interface lsu_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [31:0] data_raddr;
   logic        data_re;
   logic [31:0] data_rdata;
   logic [31:0] data_waddr;
   logic        data_we;
   logic [31:0] data_wdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_rdata,
      output req_ready, resp_valid, resp_rdata, resp_misalign,
      output data_raddr, data_re, data_waddr, data_we, data_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_misalign,
      input  data_raddr, data_re, data_waddr, data_we, data_wdata
   );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: aligned word accesses with lane extraction for loads and
// read-modify-write for byte/half stores, since the data port has no byte strobes.
module lsu_bus_master (
   input logic              clk,
   input logic              rst_n,
   lsu_bus_master_if.master bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StWrite} state_e;

   state_e      state_q;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] waddr_q;
   logic [15:0] wlo_q;
   logic [31:0] wbuf_q;
   logic        resp_valid_q;
   logic        resp_misalign_q;
   logic [31:0] resp_rdata_q;
   logic        data_re_q;
   logic        data_we_q;

   logic        req_bad;
   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic [31:0] lane_mask;
   logic [31:0] merged;

   always_comb begin
      req_bad = (bus.req_size == 2'b11) ||
                (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

      // Accepted accesses are naturally aligned, so one byte-granular shift serves all sizes.
      shamt   = {lane_q, 3'b000};
      shifted = bus.data_rdata >> shamt;

      load_ext = shifted;
      unique case (size_q)
         2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase

      lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
      merged    = (bus.data_rdata & ~lane_mask) | (({16'h0, wlo_q} << shamt) & lane_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         uns_q           <= 1'b0;
         size_q          <= 2'b00;
         lane_q          <= 2'b00;
         waddr_q         <= 32'h0;
         wlo_q           <= 16'h0;
         wbuf_q          <= 32'h0;
         resp_valid_q    <= 1'b0;
         resp_misalign_q <= 1'b0;
         resp_rdata_q    <= 32'h0;
         data_re_q       <= 1'b0;
         data_we_q       <= 1'b0;
      end else begin
         resp_valid_q    <= 1'b0;
         resp_misalign_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  uns_q        <= bus.req_unsigned;
                  size_q       <= bus.req_size;
                  lane_q       <= bus.req_addr[1:0];
                  waddr_q      <= {bus.req_addr[31:2], 2'b00};
                  wlo_q        <= bus.req_wdata[15:0];
                  resp_rdata_q <= 32'h0;
                  if (req_bad) begin
                     resp_valid_q    <= 1'b1;
                     resp_misalign_q <= 1'b1;
                  end else if (!bus.req_we) begin
                     state_q   <= StLoad;
                     data_re_q <= 1'b1;
                  end else if (bus.req_size == 2'b10) begin
                     state_q   <= StWrite;
                     wbuf_q    <= bus.req_wdata;
                     data_we_q <= 1'b1;
                  end else begin
                     state_q   <= StRmwRd;
                     data_re_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state_q      <= StIdle;
               data_re_q    <= 1'b0;
               resp_rdata_q <= load_ext;
               resp_valid_q <= 1'b1;
            end
            StRmwRd: begin
               state_q   <= StWrite;
               data_re_q <= 1'b0;
               data_we_q <= 1'b1;
               wbuf_q    <= merged;
            end
            StWrite: begin
               state_q      <= StIdle;
               data_we_q    <= 1'b0;
               resp_rdata_q <= 32'h0;
               resp_valid_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready     = (state_q == StIdle);
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_misalign = resp_misalign_q;
   assign bus.resp_rdata    = resp_rdata_q;
   assign bus.data_raddr    = waddr_q;
   assign bus.data_waddr    = waddr_q;
   assign bus.data_re       = data_re_q;
   assign bus.data_we       = data_we_q;
   assign bus.data_wdata    = wbuf_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a vector table for loads, stores and misaligned
// accesses plus hand-written RMW, back-to-back and mid-access reset sequences.
module tb_lsu_bus_master;

   logic clk = 1'b0;
   logic rst_n;

   lsu_bus_master_if bus ();

   lsu_bus_master dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Word memory behind the data port; the bench preloads it through the same write process.
   logic [31:0] mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;

   assign bus.data_rdata = mem[bus.data_raddr[9:2]];

   always @(posedge clk) begin
      if (bus.data_we) mem[bus.data_waddr[9:2]] <= bus.data_wdata;
      else if (pl_en) mem[pl_idx] <= pl_data;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
   } vec_t;

   vec_t vecs [16];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      pl_idx  = addr[9:2];
      pl_data = data;
      pl_en   = 1'b1;
      next_cycle();
      pl_en   = 1'b0;
   endtask

   task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " req_ready"}, {31'h0, bus.req_ready}, 32'h1);
      chk({tag, " resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
      chk({tag, " resp_misalign"}, {31'h0, bus.resp_misalign}, 32'h0);
      chk({tag, " resp_rdata"}, bus.resp_rdata, 32'h0);
      chk({tag, " data_re"}, {31'h0, bus.data_re}, 32'h0);
      chk({tag, " data_we"}, {31'h0, bus.data_we}, 32'h0);
      chk({tag, " data_raddr"}, bus.data_raddr, 32'h0);
      chk({tag, " data_waddr"}, bus.data_waddr, 32'h0);
      chk({tag, " data_wdata"}, bus.data_wdata, 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int re_cnt;
      int we_cnt;
      set_req(v.we, v.size, v.uns, v.addr, v.wdata);
      next_cycle();
      bus.req_valid = 1'b0;
      lat    = 1;
      re_cnt = 0;
      we_cnt = 0;
      while (!bus.resp_valid && lat < 8) begin
         re_cnt += int'(bus.data_re);
         we_cnt += int'(bus.data_we);
         next_cycle();
         lat++;
      end
      re_cnt += int'(bus.data_re);
      we_cnt += int'(bus.data_we);
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d resp_rdata", idx), bus.resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d resp_misalign", idx), {31'h0, bus.resp_misalign}, {31'h0, v.exp_mis});
      chk($sformatf("v%0d data_re cycles", idx), re_cnt, v.exp_re);
      chk($sformatf("v%0d data_we cycles", idx), we_cnt, v.exp_we);
   endtask

   initial begin
      // Table assumes mem[0x100]=0x80FF0000 and mem[0x104]=0 when it starts.
      vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 0};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0};
      vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1, 0};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_80FF, 1'b0, 2, 1, 0};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h80FF_0000, 1'b0, 2, 1, 0};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1, 0};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_0000, 1'b0, 2, 1, 0};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h103, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0};
      vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0};
      vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0};
      vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h106, 32'h1234_ABCD, 32'h0, 1'b0, 3, 1, 1};
      vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 1, 0};
      vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hABCD_0000, 1'b0, 2, 1, 0};
      vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h105, 32'hFFFF_FF12, 32'h0, 1'b0, 3, 1, 1};
      vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hABCD_1200, 1'b0, 2, 1, 0};

      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      pl_en            = 1'b0;
      pl_idx           = 8'h0;
      pl_data          = 32'h0;
      rst_n            = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      check_reset_outputs("reset");
      next_cycle();
      rst_n = 1'b1;

      // Sub-word store via read-modify-write.
      preload(32'h100, 32'h1122_3344);
      preload(32'h104, 32'h0);
      set_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_0055);
      next_cycle();
      bus.req_valid = 1'b0;
      chk("sb N+1 data_re", {31'h0, bus.data_re}, 32'h1);
      chk("sb N+1 data_raddr", bus.data_raddr, 32'h100);
      chk("sb N+1 data_we", {31'h0, bus.data_we}, 32'h0);
      chk("sb N+1 req_ready", {31'h0, bus.req_ready}, 32'h0);
      next_cycle();
      chk("sb N+2 data_we", {31'h0, bus.data_we}, 32'h1);
      chk("sb N+2 data_re", {31'h0, bus.data_re}, 32'h0);
      chk("sb N+2 data_waddr", bus.data_waddr, 32'h100);
      chk("sb N+2 data_wdata", bus.data_wdata, 32'h1155_3344);
      next_cycle();
      chk("sb N+3 resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("sb N+3 resp_misalign", {31'h0, bus.resp_misalign}, 32'h0);
      chk("sb N+3 resp_rdata", bus.resp_rdata, 32'h0);
      chk("sb mem", mem[8'h40], 32'h1155_3344);

      // Word store.
      set_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
      next_cycle();
      bus.req_valid = 1'b0;
      chk("sw N+1 data_we", {31'h0, bus.data_we}, 32'h1);
      chk("sw N+1 data_re", {31'h0, bus.data_re}, 32'h0);
      chk("sw N+1 data_waddr", bus.data_waddr, 32'h100);
      chk("sw N+1 data_wdata", bus.data_wdata, 32'hDEAD_BEEF);
      chk("sw N+1 resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      next_cycle();
      chk("sw N+2 resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("sw N+2 resp_misalign", {31'h0, bus.resp_misalign}, 32'h0);
      chk("sw mem", mem[8'h40], 32'hDEAD_BEEF);

      preload(32'h100, 32'h80FF_0000);
      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Back-to-back: the held second request is taken in the first response cycle.
      set_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      next_cycle();
      set_req(1'b1, 2'b10, 1'b0, 32'h104, 32'h55AA_55AA);
      chk("b2b N+1 req_ready", {31'h0, bus.req_ready}, 32'h0);
      chk("b2b N+1 data_re", {31'h0, bus.data_re}, 32'h1);
      chk("b2b N+1 data_we", {31'h0, bus.data_we}, 32'h0);
      next_cycle();
      chk("b2b N+2 resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b N+2 resp_rdata", bus.resp_rdata, 32'h80FF_0000);
      chk("b2b N+2 req_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("b2b N+2 data_we", {31'h0, bus.data_we}, 32'h0);
      next_cycle();
      bus.req_valid = 1'b0;
      chk("b2b N+3 data_we", {31'h0, bus.data_we}, 32'h1);
      chk("b2b N+3 data_waddr", bus.data_waddr, 32'h104);
      chk("b2b N+3 data_wdata", bus.data_wdata, 32'h55AA_55AA);
      next_cycle();
      chk("b2b N+4 resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b mem", mem[8'h41], 32'h55AA_55AA);

      // Reset during RMW_RD of a byte store aborts it without writing.
      set_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0077);
      next_cycle();
      bus.req_valid = 1'b0;
      chk("abort RMW_RD data_re", {31'h0, bus.data_re}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort data_re falls", {31'h0, bus.data_re}, 32'h0);
      chk("abort data_we low", {31'h0, bus.data_we}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         chk($sformatf("abort hold%0d data_we", i), {31'h0, bus.data_we}, 32'h0);
      end
      rst_n = 1'b1;
      #1;
      check_reset_outputs("post-abort");
      chk("abort mem unchanged", mem[8'h40], 32'h80FF_0000);
      next_cycle();
      chk("post-abort resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      run_vec('{1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_80FF, 1'b0, 2, 1, 0}, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
